// File: rtl/hex_disp_pkg.sv
// Shared seven-segment definitions for the hex display driver.
// Segment order is gfedcba, active-low.
package hex_disp_pkg;
  typedef logic [6:0] seg7;

  localparam seg7 SEG_BLANK = 7'h7F;

  localparam seg7 SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output seg7        seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display driver: shadow/active double buffer with frame-synchronous
// transfer, leading-zero suppression, decimal points, per-digit blank and blink.
module hex_scan_driver
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    blink_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic                    pending,
  output logic                    frame_done
);
  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blk_ph_q, blk_ph_d;
  logic          pending_q, pending_d;
  logic          frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0][3:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]      sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]      sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;

  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] dig_sel_n_q, dig_sel_n_d;

  logic                  tick, frame_end, dark, higher_zero;
  logic [NUM_DIGITS-1:0] lz_mask;
  seg7                   dec_seg;

  assign tick      = (cnt_q == CNT_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);

  // Suppress from the top digit down while every digit so far is zero; digit 0 always shows.
  always_comb begin
    lz_mask     = '0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      higher_zero = higher_zero && (act_data_q[i] == 4'h0);
      lz_mask[i]  = lz_en && higher_zero;
    end
  end

  seg7_decode u_dec (.nib(act_data_q[idx_q]), .seg(dec_seg));

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    frame_done_d = frame_end;
    blk_cnt_d    = blk_cnt_q;
    blk_ph_d     = blk_ph_q;
    pending_d    = pending_q;
    sh_data_d    = sh_data_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    // Blink and transfer advance on the same edge idx wraps, so a frame never mixes states.
    if (frame_end) begin
      if (blk_cnt_q == BLK_MAX) begin
        blk_cnt_d = '0;
        blk_ph_d  = ~blk_ph_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BW'(1);
      end
      if (pending_q) begin
        act_data_d  = sh_data_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
        pending_d   = 1'b0;
      end
    end
    if (load) begin
      sh_data_d  = data_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      pending_d  = 1'b1;
    end
    dark        = act_blank_q[idx_q] || lz_mask[idx_q] || (blink_en && blk_ph_q);
    seg_n_d     = dark ? SEG_BLANK : dec_seg;
    dp_n_d      = dark || !act_dp_q[idx_q];
    dig_sel_n_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      blk_ph_q     <= 1'b0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '1;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      dig_sel_n_q  <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_ph_q     <= blk_ph_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      dig_sel_n_q  <= dig_sel_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign dig_sel_n  = dig_sel_n_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;
endmodule
